// File: rtl/dmem_arbiter.sv
// Data memory port arbiter: the core has fixed priority, and a starvation counter guarantees the external port a slot.
// Define DMEM_ARB_RR_EN to replace the fixed priority with round-robin arbitration (the starvation counter is dropped).
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_rd,
    input  logic              core_wr,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    output logic              core_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_ack,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CORE_RD = 2'd1,
        EXT_RD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] core_rdata_q, ext_rdata_q;
    logic              core_req;
    logic              grant_core;
    logic              grant_ext;

    assign core_req = core_rd | core_wr;

`ifdef DMEM_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    // last_grant_q=1 means the external port won last, so the core gets priority.
    always_comb begin
        grant_core = 1'b0;
        grant_ext  = 1'b0;
        if (!reset && state_q == IDLE) begin
            grant_core = core_req && (!ext_req || last_grant_q);
            grant_ext  = ext_req && !grant_core;
        end
        last_grant_d = last_grant_q;
        if (grant_core) begin
            last_grant_d = 1'b0;
        end else if (grant_ext) begin
            last_grant_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             starve_override;

    assign starve_override = ext_req && (starve_cnt_q >= CNT_W'(MAX_WAIT));

    // The counter only measures waiting: the ack cycle of an external read is service, not denial.
    always_comb begin
        grant_core = 1'b0;
        grant_ext  = 1'b0;
        if (!reset && state_q == IDLE) begin
            grant_core = core_req && !starve_override;
            grant_ext  = ext_req && !grant_core;
        end
        starve_cnt_d = starve_cnt_q;
        if (!ext_req || grant_ext || state_q == EXT_RD) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < CNT_W'(MAX_WAIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    // Outputs stay at zero while reset is held, whatever the requesters are driving.
    always_comb begin
        state_d     = state_q;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        core_rvalid = 1'b0;
        core_stall  = 1'b0;
        ext_ack     = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    core_stall = core_req;
                    if (grant_core) begin
                        mem_addr = core_addr;
                        if (core_wr) begin
                            mem_wr     = 1'b1;
                            mem_wdata  = core_wdata;
                            core_stall = 1'b0;
                        end else begin
                            mem_rd  = 1'b1;
                            state_d = CORE_RD;
                        end
                    end else if (grant_ext) begin
                        mem_addr = ext_addr;
                        if (ext_we) begin
                            mem_wr    = 1'b1;
                            mem_wdata = ext_wdata;
                            ext_ack   = 1'b1;
                        end else begin
                            mem_rd  = 1'b1;
                            state_d = EXT_RD;
                        end
                    end
                end
                CORE_RD: begin
                    core_rvalid = 1'b1;
                    state_d     = IDLE;
                end
                EXT_RD: begin
                    ext_ack    = 1'b1;
                    core_stall = core_req;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign core_rdata = core_rvalid ? mem_rdata : core_rdata_q;
    assign ext_rdata  = (state_q == EXT_RD && !reset) ? mem_rdata : ext_rdata_q;

    // The read data registers keep the last delivered word visible between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            core_rdata_q <= '0;
            ext_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (core_rvalid) begin
                core_rdata_q <= mem_rdata;
            end
            if (state_q == EXT_RD) begin
                ext_rdata_q <= mem_rdata;
            end
        end
    end

endmodule
